vt_frame_collector: RTL and testbench
=====================================

# vt_frame_collector

Upstream stage for the combinational single-edit VT decoder. Accepts channel bits serially under a valid/ready handshake, frames them with a last marker, and packs each frame LSB-first into a DATA_WIDTH word. Alongside the word it produces the decoder's scalar inputs: received length N, the sampled n/a configuration, and precomputed digit sum and weighted syndrome. Output is a one-deep registered valid/ready slot; a completed frame waiting for that slot stalls the input.

## Interface
- DATA_WIDTH, 32: maximum packed frame bits.
- CW, 32: width of length, config, sum and syndrome fields.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bit/in_last valid.
- in_ready  out  1  collector accepts a bit this cycle.
- in_bit  in  1  channel bit.
- in_last  in  1  final bit of frame.
- n_cfg  in  CW  nominal codeword length, sampled with first bit of frame.
- a_cfg  in  CW  VT residue, sampled with first bit of frame.
- out_valid  out  1  frame held in output slot.
- out_ready  in  1  downstream consumes the slot.
- out_received  out  DATA_WIDTH  packed bits, first bit at [0], unfilled bits 0.
- out_N  out  CW  true received bit count.
- out_n, out_a  out  CW  sampled n_cfg, a_cfg.
- out_digit_sum  out  CW  count of 1s among stored bits.
- out_syndrome  out  CW  sum of (i+1) over stored bits i with bit 1.
- out_overflow  out  1  frame exceeded DATA_WIDTH bits.
- out_len_err  out  1  |out_N - out_n| > 1.

## Operation
- Accept = in_valid && in_ready. Bit index i = current count; count increments per accept.
- i < DATA_WIDTH: bit written to shift word position i; sum += bit; syndrome += bit ? i+1 : 0.
- i >= DATA_WIDTH: bit dropped, overflow flag set, count still increments (saturates at all-ones).
- First accept of frame (count == 0) latches n_cfg, a_cfg.
- States: COLLECT (in_ready=1), HOLD (in_ready=0, complete frame waiting).
- COLLECT, accept with in_last: if slot free (!out_valid || out_ready) load slot at this edge, clear collector, stay COLLECT; else go HOLD.
- HOLD: when slot free, load slot, clear collector, go COLLECT.
- out_len_err computed from final N and n at load and registered with the slot.
- Slot cleared (out_valid=0) on out_ready with no simultaneous load; simultaneous consume+load replaces contents with out_valid staying 1.
- Every frame has at least one bit; zero-length frames do not exist.

## Timing
- Reset: state COLLECT, in_ready=1, out_valid=0, all out_* fields 0, count/sum/syndrome/shift word 0.
- Reset mid-frame discards partial frame and held frame.
- Latency: out_valid rises the edge that accepts in_last when slot free; otherwise the edge after slot frees.
- Throughput: one frame per cycle for single-bit frames with out_ready held 1.
- in_ready is a registered state decode, not combinational on out_ready.
- out_* stable while out_valid && !out_ready.
- Syndrome arithmetic CW bits, no modulo; never wraps for DATA_WIDTH <= 2^(CW/2).

## Structure
- Package vt_pkg: DATA_WIDTH/CW defaults, state enum (COLLECT, HOLD), packed struct vt_frame_t {received, N, n, a, digit_sum, syndrome, overflow, len_err}; shared with the decoder.
- Sub-module vt_out_slot: one-deep valid/ready register of vt_frame_t.

## Test plan
- Bits 1,0,1,1,0,0,1,0 (last on 8th), n_cfg=8, a_cfg=15, out_ready=1 -> received=0x4D, N=8, digit_sum=4, syndrome=15, len_err=0, overflow=0.
- out_ready=0, frames 3'b101 then 2'b11 -> in_ready drops after second last; raising out_ready delivers received=0x5 N=3 then 0x3 N=2, in order, no loss.
- 34-bit frame of all 1s -> overflow=1, N=34, received=0xFFFFFFFF, digit_sum=32, syndrome=528.
- 5-bit frame with n_cfg=8 -> len_err=1; 7-bit frame with n_cfg=8 -> len_err=0.
- rst_n low after 3 accepted bits, then 2-bit frame 1,1 -> received=0x3, N=2, no stale bits, out_valid 0 during reset.
- Back-to-back single-bit frames 1,0,1 with in_last=1 each, out_ready=1 -> out_valid held 3 cycles, received 1,0,1, N=1 each.

Source files
------------

// File: rtl/vt_pkg.sv
// Shared types and constants for the VT frame collector and the single-edit decoder.
// Each frame bundles the packed received bits with the decoder's scalar inputs.
package vt_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CW         = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } vt_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] received;
        logic [CW-1:0]         N;
        logic [CW-1:0]         n;
        logic [CW-1:0]         a;
        logic [CW-1:0]         digit_sum;
        logic [CW-1:0]         syndrome;
        logic                  overflow;
        logic                  len_err;
    } vt_frame_t;

    // Received length is unusable for a single-edit decode when it differs from n by more than one
    function automatic logic len_err_f(input logic [CW-1:0] rx_len, input logic [CW-1:0] nom_len);
        logic [CW-1:0] diff;
        diff = (rx_len >= nom_len) ? rx_len - nom_len : nom_len - rx_len;
        return diff > CW'(1);
    endfunction

endpackage

// File: rtl/vt_out_slot.sv
// One-deep registered valid/ready holding slot for a completed frame.
// A load always wins over a consume, so consume+load keeps out_valid high.
module vt_out_slot
    import vt_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  vt_frame_t frame_in,
    input  logic      out_ready,
    output logic      out_valid,
    output vt_frame_t frame,
    output logic      free_c
);

    assign free_c = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            frame     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            frame     <= frame_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vt_frame_collector.sv
// Serial-to-frame collector for the VT decoder: packs bits LSB-first and accumulates
// length, digit sum and weighted syndrome, then hands the frame to a one-deep output slot.
module vt_frame_collector
    import vt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_bit,
    input  logic                  in_last,
    input  logic [CW-1:0]         n_cfg,
    input  logic [CW-1:0]         a_cfg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_received,
    output logic [CW-1:0]         out_N,
    output logic [CW-1:0]         out_n,
    output logic [CW-1:0]         out_a,
    output logic [CW-1:0]         out_digit_sum,
    output logic [CW-1:0]         out_syndrome,
    output logic                  out_overflow,
    output logic                  out_len_err
);

    vt_state_e state;
    vt_state_e state_next;
    vt_frame_t col;           // frame under construction; col.N doubles as the bit index
    vt_frame_t col_next_c;
    vt_frame_t load_frame_c;
    vt_frame_t slot_frame;
    logic      accept_c;
    logic      load_c;
    logic      slot_free_c;

    assign accept_c = in_valid && in_ready;

    // Collector contents after absorbing the bit currently on the input
    always_comb begin : bit_update
        col_next_c = col;
        if (col.N == '0) begin
            col_next_c.n = n_cfg;
            col_next_c.a = a_cfg;
        end
        if (col.N < CW'(DATA_WIDTH)) begin
            col_next_c.received  = col.received | (DATA_WIDTH'(in_bit) << col.N);
            col_next_c.digit_sum = col.digit_sum + CW'(in_bit);
            col_next_c.syndrome  = col.syndrome + (in_bit ? col.N + CW'(1) : CW'(0));
        end else begin
            col_next_c.overflow = 1'b1;
        end
        if (col.N != '1) begin
            col_next_c.N = col.N + CW'(1);
        end
    end

    always_comb begin : fsm_next
        state_next   = state;
        load_c       = 1'b0;
        load_frame_c = col_next_c;
        case (state)
            COLLECT: begin
                if (accept_c && in_last) begin
                    if (slot_free_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                load_frame_c = col;
                if (slot_free_c) begin
                    load_c     = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
        load_frame_c.len_err = len_err_f(load_frame_c.N, load_frame_c.n);
    end

    // in_ready is a registered decode of the next state, never a path from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == COLLECT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
        end else if (load_c) begin
            col <= '0;
        end else if (accept_c) begin
            col <= col_next_c;
        end
    end

    vt_out_slot u_out_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .frame_in  (load_frame_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .frame     (slot_frame),
        .free_c    (slot_free_c)
    );

    assign out_received  = slot_frame.received;
    assign out_N         = slot_frame.N;
    assign out_n         = slot_frame.n;
    assign out_a         = slot_frame.a;
    assign out_digit_sum = slot_frame.digit_sum;
    assign out_syndrome  = slot_frame.syndrome;
    assign out_overflow  = slot_frame.overflow;
    assign out_len_err   = slot_frame.len_err;

endmodule

// File: tb/tb_vt_frame_collector.sv
// Self-checking bench for vt_frame_collector: directed vector table, handshake corner
// sequences and randomized frames scored against an arithmetic reference model.
module tb_vt_frame_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic [31:0] n_cfg;
    logic [31:0] a_cfg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_received;
    logic [31:0] out_N;
    logic [31:0] out_n;
    logic [31:0] out_a;
    logic [31:0] out_digit_sum;
    logic [31:0] out_syndrome;
    logic        out_overflow;
    logic        out_len_err;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] received;
        logic [31:0] N;
        logic [31:0] n;
        logic [31:0] a;
        logic [31:0] sum;
        logic [31:0] syn;
        logic        ovf;
        logic        lerr;
    } exp_t;

    typedef struct {
        int          len;
        logic [63:0] bits;
        logic [31:0] n;
        logic [31:0] a;
        exp_t        want;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[7];

    logic rand_en   = 1'b0;
    logic rnd_bit   = 1'b1;
    logic ready_val = 1'b0;

    assign out_ready = rand_en ? rnd_bit : ready_val;

    vt_frame_collector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bit        (in_bit),
        .in_last       (in_last),
        .n_cfg         (n_cfg),
        .a_cfg         (a_cfg),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_received  (out_received),
        .out_N         (out_N),
        .out_n         (out_n),
        .out_a         (out_a),
        .out_digit_sum (out_digit_sum),
        .out_syndrome  (out_syndrome),
        .out_overflow  (out_overflow),
        .out_len_err   (out_len_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) rnd_bit <= ($urandom_range(0, 9) < 7);

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void fail(input string name);
        tests++;
        errors++;
        $display("FAIL %s: event did not occur within its bound", name);
    endfunction

    function automatic exp_t snap();
        exp_t s;
        s.received = out_received;
        s.N        = out_N;
        s.n        = out_n;
        s.a        = out_a;
        s.sum      = out_digit_sum;
        s.syn      = out_syndrome;
        s.ovf      = out_overflow;
        s.lerr     = out_len_err;
        return s;
    endfunction

    function automatic void cmp_frame(input string tag, input exp_t act, input exp_t req);
        chk({tag, ".received"}, 64'(act.received), 64'(req.received));
        chk({tag, ".N"},        64'(act.N),        64'(req.N));
        chk({tag, ".n"},        64'(act.n),        64'(req.n));
        chk({tag, ".a"},        64'(act.a),        64'(req.a));
        chk({tag, ".sum"},      64'(act.sum),      64'(req.sum));
        chk({tag, ".syndrome"}, 64'(act.syn),      64'(req.syn));
        chk({tag, ".overflow"}, 64'(act.ovf),      64'(req.ovf));
        chk({tag, ".len_err"},  64'(act.lerr),     64'(req.lerr));
    endfunction

    // Reference: frame fields straight from the bit list and the length rules
    function automatic exp_t model(input logic [63:0] bits, input int len, input logic [31:0] n,
                                   input logic [31:0] a);
        exp_t e;
        int   d;
        e = '{default: '0};
        e.N = 32'(len);
        e.n = n;
        e.a = a;
        for (int i = 0; i < len; i++) begin
            if (bits[i] && i < 32) begin
                e.received[i] = 1'b1;
                e.sum         = e.sum + 32'd1;
                e.syn         = e.syn + 32'(i + 1);
            end
        end
        e.ovf  = (len > 32);
        d      = len - int'(n);
        e.lerr = (d > 1) || (d < -1);
        return e;
    endfunction

    // Scoreboard: consumes a frame whenever out_valid && out_ready, checks hold stability
    exp_t held;
    logic held_ok = 1'b0;
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        #2;
        if (!rst_n) begin
            chk("reset_out_valid", 64'(out_valid), 64'd0);
            chk("reset_in_ready", 64'(in_ready), 64'd1);
            held_ok = 1'b0;
        end else begin
            cur = snap();
            if (out_valid && held_ok) cmp_frame("stable", cur, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_frame");
                end else begin
                    e = exp_q.pop_front();
                    cmp_frame("frame", cur, e);
                end
                held_ok = 1'b0;
            end else if (out_valid) begin
                held    = cur;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
        end
    end

    // Present one bit at a negedge and return at the negedge after it is accepted
    task automatic send_bit(input logic b, input logic last, input logic [31:0] n, input logic [31:0] a);
        int guard = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        n_cfg    = n;
        a_cfg    = a;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail("in_ready_timeout");
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Config is changed after the first bit to confirm it is only sampled there
    task automatic send_frame(input logic [63:0] bits, input int len, input logic [31:0] n,
                              input logic [31:0] a, input logic scramble);
        for (int i = 0; i < len; i++) begin
            if (i == 0 || !scramble) send_bit(bits[i], (i == len - 1), n, a);
            else                     send_bit(bits[i], (i == len - 1), $urandom, $urandom);
        end
    endtask

    task automatic drain();
        int g = 0;
        ready_val = 1'b1;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            #3;
            g++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (cycles) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   len;
        int   nn;
        logic [63:0] bits;
        logic [31:0] a;

        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        n_cfg = '0;   a_cfg = '0;

        vt[0] = '{8,  64'h4D,         32'd8,  32'd15, '{32'h4D,       32'd8,  32'd8,  32'd15, 32'd4,  32'd15,  1'b0, 1'b0}};
        vt[1] = '{34, 64'h3_FFFF_FFFF, 32'd34, 32'd5,  '{32'hFFFF_FFFF, 32'd34, 32'd34, 32'd5,  32'd32, 32'd528, 1'b1, 1'b0}};
        vt[2] = '{5,  64'h16,         32'd8,  32'd3,  '{32'h16,       32'd5,  32'd8,  32'd3,  32'd3,  32'd10,  1'b0, 1'b1}};
        vt[3] = '{7,  64'h7F,         32'd8,  32'd0,  '{32'h7F,       32'd7,  32'd8,  32'd0,  32'd7,  32'd28,  1'b0, 1'b0}};
        vt[4] = '{1,  64'h1,          32'd1,  32'd1,  '{32'h1,        32'd1,  32'd1,  32'd1,  32'd1,  32'd1,   1'b0, 1'b0}};
        vt[5] = '{9,  64'h0,          32'd8,  32'd2,  '{32'h0,        32'd9,  32'd8,  32'd2,  32'd0,  32'd0,   1'b0, 1'b0}};
        vt[6] = '{10, 64'h3FF,        32'd8,  32'd9,  '{32'h3FF,      32'd10, 32'd8,  32'd9,  32'd10, 32'd55,  1'b0, 1'b1}};

        repeat (2) @(negedge clk);
        chk("init_in_ready",  64'(in_ready),      64'd1);
        chk("init_out_valid", 64'(out_valid),     64'd0);
        chk("init_received",  64'(out_received),  64'd0);
        chk("init_N",         64'(out_N),         64'd0);
        chk("init_n",         64'(out_n),         64'd0);
        chk("init_a",         64'(out_a),         64'd0);
        chk("init_sum",       64'(out_digit_sum), 64'd0);
        chk("init_syndrome",  64'(out_syndrome),  64'd0);
        chk("init_overflow",  64'(out_overflow),  64'd0);
        chk("init_len_err",   64'(out_len_err),   64'd0);
        rst_n = 1'b1;

        // Directed vector table
        ready_val = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(vt[k].want);
            send_frame(vt[k].bits, vt[k].len, vt[k].n, vt[k].a, 1'b0);
            drain();
        end

        // Full slot plus a second completed frame stalls the input until released
        ready_val = 1'b0;
        exp_q.push_back('{32'h5, 32'd3, 32'd3, 32'd0, 32'd2, 32'd4, 1'b0, 1'b0});
        exp_q.push_back('{32'h3, 32'd2, 32'd2, 32'd0, 32'd2, 32'd3, 1'b0, 1'b0});
        send_frame(64'h5, 3, 32'd3, 32'd0, 1'b0);
        send_frame(64'h3, 2, 32'd2, 32'd0, 1'b0);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("hold_in_ready_still", 64'(in_ready),     64'd0);
        chk("hold_out_valid",      64'(out_valid),    64'd1);
        chk("hold_first_word",     64'(out_received), 64'h5);
        drain();
        chk("hold_release_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a frame drops the partial bits
        ready_val = 1'b1;
        for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0, 32'd3, 32'd7);
        do_reset(2);
        chk("rst_mid_out_valid", 64'(out_valid),    64'd0);
        chk("rst_mid_received",  64'(out_received), 64'd0);
        chk("rst_mid_in_ready",  64'(in_ready),     64'd1);
        exp_q.push_back('{32'h3, 32'd2, 32'd2, 32'd7, 32'd2, 32'd3, 1'b0, 1'b0});
        send_frame(64'h3, 2, 32'd2, 32'd7, 1'b0);
        drain();

        // Back-to-back single-bit frames at full rate
        ready_val = 1'b1;
        exp_q.push_back('{32'h1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0});
        exp_q.push_back('{32'h0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0});
        exp_q.push_back('{32'h1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            send_bit((k != 1), 1'b1, 32'd1, 32'd0);
            chk("b2b_out_valid", 64'(out_valid), 64'd1);
        end
        drain();

        // Randomized frames with random downstream backpressure
        rand_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len  = int'($urandom_range(1, 40));
            bits = {$urandom, $urandom};
            nn   = len + int'($urandom_range(0, 4)) - 2;
            if (nn < 0) nn = 0;
            a    = $urandom;
            exp_q.push_back(model(bits, len, 32'(nn), a));
            send_frame(bits, len, 32'(nn), a, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_en = 1'b0;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
